// File: rtl/axi_b_router_pkg.sv
// Shared types and helpers for the AXI B-channel router (optional build macro: AXI_B_ERRCNT_EN).
package axi_b_router_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int unsigned SINK_MASTER  = 0;
    localparam logic [15:0] ERR_CNT_MAX  = 16'hFFFF;

    // SLVERR and DECERR are the two responses with the MSB set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

    function automatic logic master_is_sink(input int unsigned mst, input int unsigned num_masters);
        return (mst == SINK_MASTER) || (mst >= num_masters);
    endfunction

endpackage

// File: rtl/axi_b_router_if.sv
// B-channel bundle between slave ports, the router and master ports.
interface axi_b_router_if #(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 8,
    parameter int ID_BITS     = 4,
    parameter int MASTER_BITS = 2,
    parameter int RESP_BITS   = 2
);
    localparam int IDS_BITS = ID_BITS + MASTER_BITS;

    logic [NUM_SLAVES*IDS_BITS-1:0]   s_bids_i;
    logic [NUM_SLAVES*RESP_BITS-1:0]  s_bresp_i;
    logic [NUM_SLAVES-1:0]            s_bvalid_i;
    logic [NUM_SLAVES-1:0]            s_bready_o;
    logic [NUM_MASTERS*ID_BITS-1:0]   m_bid_o;
    logic [NUM_MASTERS*RESP_BITS-1:0] m_bresp_o;
    logic [NUM_MASTERS-1:0]           m_bvalid_o;
    logic [NUM_MASTERS-1:0]           m_bready_i;

    // Router side.
    modport slave (
        input  s_bids_i, s_bresp_i, s_bvalid_i, m_bready_i,
        output s_bready_o, m_bid_o, m_bresp_o, m_bvalid_o
    );

    // Environment side: drives slave beats and master ready.
    modport master (
        output s_bids_i, s_bresp_i, s_bvalid_i, m_bready_i,
        input  s_bready_o, m_bid_o, m_bresp_o, m_bvalid_o
    );

endinterface

// File: rtl/axi_b_router_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and index, pointer moves past the winner on advance.
module rr_arbiter #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand [N];

    // Candidate order starts at the pointer and wraps around.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_cand[k] = IW'((32'(r_ptr) + 32'(k)) % 32'(N));
        end
    end

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_any && i_req[w_cand[k]]) begin
                o_any             = 1'b1;
                o_idx             = w_cand[k];
                o_grant[w_cand[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && o_any) begin
            r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
        end
    end

endmodule

// File: rtl/axi_b_router.sv
// AXI B-channel router: round-robin pick over slave B beats, one-entry registered slot, routed by BID master field.
// Optional error counter output err_cnt_o is built when AXI_B_ERRCNT_EN is defined.
module axi_b_router
    import axi_b_router_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int NUM_SLAVES  = 8,
    parameter int ID_BITS     = 4,
    parameter int MASTER_BITS = 2,
    parameter int RESP_BITS   = 2
) (
    input  logic           clk,
    input  logic           rst,
    axi_b_router_if.slave  bus
`ifdef AXI_B_ERRCNT_EN
    ,
    output logic [15:0]    err_cnt_o
`endif
);

    localparam int IDS_BITS = ID_BITS + MASTER_BITS;
    localparam int IDX_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    slot_state_t              r_state;
    logic [ID_BITS-1:0]       r_id;
    logic [RESP_BITS-1:0]     r_resp;
    logic [NUM_MASTERS-1:0]   r_mvalid;

    logic [NUM_SLAVES-1:0]    w_grant;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_any;
    logic                     w_drain;
    logic                     w_accept_ok;
    logic                     w_advance;
    logic [IDS_BITS-1:0]      w_sel_ids;
    logic [RESP_BITS-1:0]     w_sel_resp;
    logic [MASTER_BITS-1:0]   w_sel_mst;
    logic [NUM_MASTERS-1:0]   w_next_mvalid;

    rr_arbiter #(.N(NUM_SLAVES)) u_arb (
        .clk       (clk),
        .rst_n     (rst),
        .i_req     (bus.s_bvalid_i),
        .i_advance (w_advance),
        .o_grant   (w_grant),
        .o_idx     (w_idx),
        .o_any     (w_any)
    );

    // A sunk beat has no master lane valid, so it leaves the slot unconditionally.
    assign w_drain     = (r_state == SLOT_FULL) &&
                         ((r_mvalid == '0) || ((r_mvalid & bus.m_bready_i) != '0));
    assign w_accept_ok = rst && ((r_state == SLOT_EMPTY) || w_drain);
    assign w_advance   = w_accept_ok && w_any;

    assign bus.s_bready_o = w_grant & {NUM_SLAVES{w_accept_ok}};

    assign w_sel_ids  = bus.s_bids_i[w_idx*IDS_BITS +: IDS_BITS];
    assign w_sel_resp = bus.s_bresp_i[w_idx*RESP_BITS +: RESP_BITS];
    assign w_sel_mst  = w_sel_ids[IDS_BITS-1:ID_BITS];

    // Lane 0 never gets a valid, and out-of-range master fields match no lane.
    always_comb begin
        w_next_mvalid = '0;
        for (int m = 1; m < NUM_MASTERS; m++) begin
            if (32'(w_sel_mst) == 32'(m)) begin
                w_next_mvalid[m] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= SLOT_EMPTY;
            r_id     <= '0;
            r_resp   <= '0;
            r_mvalid <= '0;
        end else begin
            case (r_state)
                SLOT_EMPTY: begin
                    if (w_advance) begin
                        r_state  <= SLOT_FULL;
                        r_id     <= w_sel_ids[ID_BITS-1:0];
                        r_resp   <= w_sel_resp;
                        r_mvalid <= w_next_mvalid;
                    end
                end
                SLOT_FULL: begin
                    if (w_advance) begin
                        r_id     <= w_sel_ids[ID_BITS-1:0];
                        r_resp   <= w_sel_resp;
                        r_mvalid <= w_next_mvalid;
                    end else if (w_drain) begin
                        r_state  <= SLOT_EMPTY;
                        r_mvalid <= '0;
                    end
                end
                default: begin
                    r_state  <= SLOT_EMPTY;
                    r_mvalid <= '0;
                end
            endcase
        end
    end

    assign bus.m_bvalid_o = r_mvalid;

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_lane
        assign bus.m_bid_o[m*ID_BITS +: ID_BITS]       = r_id;
        assign bus.m_bresp_o[m*RESP_BITS +: RESP_BITS] = r_resp;
    end

`ifdef AXI_B_ERRCNT_EN
    logic        w_sel_sink;
    logic        w_sel_err;
    logic [15:0] r_err_cnt;

    assign w_sel_sink = master_is_sink(32'(w_sel_mst), NUM_MASTERS);
    assign w_sel_err  = resp_is_err(w_sel_resp[1:0]) || w_sel_sink;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_advance && w_sel_err && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt_o = r_err_cnt;
`endif

    // Slaves must keep BVALID up until their beat is taken.
    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_sva
        a_bvalid_hold: assert property (@(posedge clk) disable iff (!rst)
            (bus.s_bvalid_i[s] && !bus.s_bready_o[s]) |=> bus.s_bvalid_i[s]);
    end

    a_bready_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(bus.s_bready_o));

    a_bready_needs_valid: assert property (@(posedge clk) disable iff (!rst)
        ((bus.s_bready_o & ~bus.s_bvalid_i) == '0));

endmodule

// File: tb/tb_axi_b_router.sv
// Randomized bench for axi_b_router with a transaction-level slot/round-robin reference model.
module tb_axi_b_router;

    localparam int NM   = 3;
    localparam int NS   = 8;
    localparam int IDB  = 4;
    localparam int MB   = 2;
    localparam int RB   = 2;
    localparam int IDSB = IDB + MB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_b_router_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ID_BITS(IDB),
                      .MASTER_BITS(MB), .RESP_BITS(RB)) bus ();

`ifdef AXI_B_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    axi_b_router #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .ID_BITS(IDB),
                   .MASTER_BITS(MB), .RESP_BITS(RB)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef AXI_B_ERRCNT_EN
        ,
        .err_cnt_o (err_cnt)
`endif
    );

    typedef struct packed {
        logic [IDSB-1:0] ids;
        logic [RB-1:0]   resp;
    } beat_t;

    beat_t          sq [NS][$];
    logic [NS-1:0]  slv_vld;
    bit             gap_off;
    bit             mrdy_force;
    logic [NM-1:0]  mrdy_val;
    int             n_chk;
    int             n_fail;

    // Reference model state: one slot, RR pointer, saturating error count.
    bit             mdl_full;
    int             mdl_mst;
    logic [IDB-1:0] mdl_id;
    logic [RB-1:0]  mdl_resp;
    int             mdl_ptr;
    int             mdl_err;

    int             s_hs_cnt;
    int             m_hs_cnt;
    int             dut_grant_log[$];

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [MB-1:0] mst, input logic [IDB-1:0] id,
                        input logic [RB-1:0] resp);
        beat_t b;
        b.ids  = {mst, id};
        b.resp = resp;
        sq[s].push_back(b);
    endtask

    function automatic bit any_pending();
        bit p;
        p = mdl_full;
        for (int i = 0; i < NS; i++) if (sq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        tick(1);
        while (any_pending() && n < budget) begin
            @(posedge clk);
            n++;
        end
        #3;
        if (n >= budget) chk_eq("idle_timeout", 32'(n), 32'(0));
        tick(1);
    endtask

    task automatic clear_and_release();
        for (int i = 0; i < NS; i++) sq[i].delete();
        slv_vld          = '0;
        bus.s_bvalid_i   = '0;
        mdl_full         = 1'b0;
        mdl_ptr          = 0;
        mdl_err          = 0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_and_release();
    endtask

    // Input driver: slaves present queue heads, holding valid until taken.
    logic [NS-1:0]      drv_v;
    logic [NS*IDSB-1:0] drv_ids;
    logic [NS*RB-1:0]   drv_rs;
    initial begin
        bus.s_bids_i   = '0;
        bus.s_bresp_i  = '0;
        bus.s_bvalid_i = '0;
        bus.m_bready_i = '0;
        forever begin
            @(posedge clk);
            #1;
            drv_v   = '0;
            drv_ids = '0;
            drv_rs  = '0;
            for (int i = 0; i < NS; i++) begin
                if (!slv_vld[i] && sq[i].size() != 0 && (gap_off || $urandom_range(0, 3) != 0))
                    slv_vld[i] = 1'b1;
                drv_v[i] = slv_vld[i];
                if (sq[i].size() != 0) begin
                    drv_ids[i*IDSB +: IDSB] = sq[i][0].ids;
                    drv_rs[i*RB +: RB]      = sq[i][0].resp;
                end
            end
            bus.s_bvalid_i = drv_v;
            bus.s_bids_i   = drv_ids;
            bus.s_bresp_i  = drv_rs;
            bus.m_bready_i = mrdy_force ? mrdy_val : NM'($urandom);
        end
    end

    // Monitor and model, evaluated mid-cycle.
    logic [NM-1:0] exp_mv;
    logic [NS-1:0] exp_rdy;
    bit            mon_drain;
    bit            mon_can;
    int            mon_win;
    int            mon_j;
    beat_t         mon_b;
    always @(negedge clk) begin
        if (rst) begin
            exp_mv = '0;
            if (mdl_full && mdl_mst >= 1 && mdl_mst < NM) exp_mv[mdl_mst] = 1'b1;
            chk_eq("m_bvalid", 32'(bus.m_bvalid_o), 32'(exp_mv));
            if (exp_mv != '0) begin
                chk_eq("m_bid",   32'(bus.m_bid_o[mdl_mst*IDB +: IDB]), 32'(mdl_id));
                chk_eq("m_bresp", 32'(bus.m_bresp_o[mdl_mst*RB +: RB]), 32'(mdl_resp));
            end
            mon_drain = mdl_full && (exp_mv == '0 || (exp_mv & bus.m_bready_i) != '0);
            mon_can   = !mdl_full || mon_drain;
            mon_win   = -1;
            if (mon_can) begin
                for (int k = 0; k < NS; k++) begin
                    mon_j = (mdl_ptr + k) % NS;
                    if (mon_win < 0 && bus.s_bvalid_i[mon_j]) mon_win = mon_j;
                end
            end
            exp_rdy = '0;
            if (mon_win >= 0) exp_rdy[mon_win] = 1'b1;
            chk_eq("s_bready", 32'(bus.s_bready_o), 32'(exp_rdy));
`ifdef AXI_B_ERRCNT_EN
            chk_eq("err_cnt", 32'(err_cnt), 32'(mdl_err));
`endif
            if (mon_win >= 0) begin
                mon_b    = sq[mon_win][0];
                mdl_full = 1'b1;
                mdl_mst  = int'(mon_b.ids[IDSB-1:IDB]);
                mdl_id   = mon_b.ids[IDB-1:0];
                mdl_resp = mon_b.resp;
                mdl_ptr  = (mon_win + 1) % NS;
                if (mon_b.resp >= 2'd2 || mdl_mst == 0 || mdl_mst >= NM)
                    mdl_err = (mdl_err < 65535) ? mdl_err + 1 : 65535;
            end else if (mon_drain) begin
                mdl_full = 1'b0;
            end
            for (int m = 0; m < NM; m++)
                if (bus.m_bvalid_o[m] && bus.m_bready_i[m]) m_hs_cnt++;
            for (int i = 0; i < NS; i++) begin
                if (bus.s_bvalid_i[i] && bus.s_bready_o[i]) begin
                    s_hs_cnt++;
                    dut_grant_log.push_back(i);
                    if (sq[i].size() != 0) void'(sq[i].pop_front());
                    slv_vld[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1);
    end

    int s0, m0, exp_nonsink, wait_n;
    initial begin
        n_chk = 0; n_fail = 0; s_hs_cnt = 0; m_hs_cnt = 0;
        slv_vld = '0; gap_off = 1'b1; mrdy_force = 1'b1; mrdy_val = '1;
        mdl_full = 1'b0; mdl_ptr = 0; mdl_err = 0; mdl_mst = 0; mdl_id = '0; mdl_resp = '0;
        #2;
        rst = 1'b0;
        tick(2);
        chk_eq("rst_m_bvalid", 32'(bus.m_bvalid_o), 32'(0));
        chk_eq("rst_s_bready", 32'(bus.s_bready_o), 32'(0));
        chk_eq("rst_m_bid",    32'(bus.m_bid_o),    32'(0));
        chk_eq("rst_m_bresp",  32'(bus.m_bresp_o),  32'(0));
`ifdef AXI_B_ERRCNT_EN
        chk_eq("rst_err_cnt",  32'(err_cnt),        32'(0));
`endif
        clear_and_release();

        // Single beat from slave 3 to master 1.
        push(3, 2'd1, 4'h5, 2'b00);
        @(posedge clk); @(negedge clk);
        chk_eq("t2_s_bready", 32'(bus.s_bready_o), 32'h08);
        chk_eq("t2_m_bvalid_pre", 32'(bus.m_bvalid_o), 32'(0));
        @(negedge clk);
        chk_eq("t2_m_bvalid", 32'(bus.m_bvalid_o), 32'b010);
        chk_eq("t2_m_bid", 32'(bus.m_bid_o[IDB +: IDB]), 32'h5);
        @(negedge clk);
        chk_eq("t2_empty", 32'(bus.m_bvalid_o), 32'(0));
        wait_idle(50);

        // Backpressure on master 2 with another slave waiting.
        mrdy_val = 3'b000;
        push(5, 2'd2, 4'hA, 2'b01);
        push(1, 2'd1, 4'h3, 2'b00);
        wait_n = 0;
        @(negedge clk);
        while (!bus.m_bvalid_o[2] && wait_n < 20) begin @(negedge clk); wait_n++; end
        chk_eq("t4_reach_full", 32'(wait_n < 20), 32'(1));
        repeat (5) begin
            @(negedge clk);
            chk_eq("t4_m_bvalid", 32'(bus.m_bvalid_o), 32'b100);
            chk_eq("t4_m_bid",    32'(bus.m_bid_o[2*IDB +: IDB]), 32'hA);
            chk_eq("t4_m_bresp",  32'(bus.m_bresp_o[2*RB +: RB]), 32'h1);
            chk_eq("t4_s_bready", 32'(bus.s_bready_o), 32'(0));
        end

        // Reset while the slot is full and slave 1 still requests.
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk_eq("t1_m_bvalid", 32'(bus.m_bvalid_o), 32'(0));
        chk_eq("t1_s_bready", 32'(bus.s_bready_o), 32'(0));
        chk_eq("t1_m_bid",    32'(bus.m_bid_o),    32'(0));
`ifdef AXI_B_ERRCNT_EN
        chk_eq("t1_err_cnt",  32'(err_cnt),        32'(0));
`endif
        clear_and_release();

        // Contention from slaves 0, 2, 7 right after reset.
        mrdy_val = 3'b111;
        dut_grant_log.delete();
        for (int n = 0; n < 3; n++) begin
            push(0, 2'd1, 4'(n), 2'b00);
            push(2, 2'd2, 4'(n + 4), 2'b00);
            push(7, 2'd1, 4'(n + 8), 2'b01);
        end
        wait_idle(100);
        chk_eq("t3_count", 32'(dut_grant_log.size()), 32'(9));
        if (dut_grant_log.size() >= 4) begin
            chk_eq("t3_g0", 32'(dut_grant_log[0]), 32'(0));
            chk_eq("t3_g1", 32'(dut_grant_log[1]), 32'(2));
            chk_eq("t3_g2", 32'(dut_grant_log[2]), 32'(7));
            chk_eq("t3_g3", 32'(dut_grant_log[3]), 32'(0));
        end

        // Sink beats: master field 0 and 3.
        s0 = s_hs_cnt; m0 = m_hs_cnt;
        push(4, 2'd0, 4'h1, 2'b00);
        push(6, 2'd3, 4'h2, 2'b00);
        wait_idle(50);
        chk_eq("t5_s_hs", 32'(s_hs_cnt - s0), 32'(2));
        chk_eq("t5_m_hs", 32'(m_hs_cnt - m0), 32'(0));
`ifdef AXI_B_ERRCNT_EN
        chk_eq("t5_err_cnt", 32'(err_cnt), 32'(2));
`endif

        // Error responses from a fresh reset.
        do_reset();
        m0 = m_hs_cnt;
        push(2, 2'd1, 4'h7, 2'b10);
        push(2, 2'd1, 4'h8, 2'b11);
        push(2, 2'd1, 4'h9, 2'b00);
        wait_idle(50);
        chk_eq("t6_m_hs", 32'(m_hs_cnt - m0), 32'(3));
`ifdef AXI_B_ERRCNT_EN
        chk_eq("t6_err_cnt", 32'(err_cnt), 32'(2));
`endif

        // Randomized traffic with gaps and random master ready.
        gap_off = 1'b0; mrdy_force = 1'b0;
        exp_nonsink = 0; m0 = m_hs_cnt;
        for (int i = 0; i < NS; i++) begin
            for (int n = 0; n < 40; n++) begin
                logic [MB-1:0] rm;
                rm = MB'($urandom_range(0, 3));
                push(i, rm, IDB'($urandom), RB'($urandom));
                if (rm == 2'd1 || rm == 2'd2) exp_nonsink++;
            end
        end
        wait_idle(20000);
        chk_eq("rand_m_hs", 32'(m_hs_cnt - m0), 32'(exp_nonsink));

`ifdef AXI_B_ERRCNT_EN
        // Drive the counter to saturation with sunk beats.
        do_reset();
        gap_off = 1'b1; mrdy_force = 1'b1; mrdy_val = 3'b111;
        for (int i = 0; i < NS; i++)
            for (int n = 0; n < 8200; n++) push(i, 2'd0, IDB'(n), 2'b00);
        wait_idle(70000);
        chk_eq("sat_err_cnt", 32'(err_cnt), 32'hFFFF);
        push(1, 2'd1, 4'hC, 2'b10);
        wait_idle(50);
        chk_eq("sat_hold", 32'(err_cnt), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
